prefix_rr_arbiter: RTL

Round-robin arbiter with multi-cycle ownership and a bounded hold time, sharing one resource among `p_REQUESTERS` requesters. Find-first-set selection uses the team's log-depth prefix-OR network, so arbitration depth stays O(log N). The arbiter sits in front of any shared datapath port: bus master slot, RAM port, or shared prefix unit. It issues a registered one-hot grant plus an encoded index.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/prefix_rr_arbiter_if.sv | 27 ++
 rtl/prefix_rr_arbiter_prefix_or.sv | 29 ++
 rtl/prefix_rr_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and one-hot helper for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // Encodes a one-hot vector (up to 64 bits) into its bit index; zero input gives 0.
    function automatic int f_onehot_to_idx(input logic [63:0] iv_onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (iv_onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prefix_rr_arbiter_if.sv
// rtl/prefix_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
//   iwv_req        : request level per requester (requester side drives)
//   owv_grant      : registered one-hot grant
//   ow_grant_valid : grant is non-zero
//   owv_grant_idx  : encoded owner index, holds last value while not valid
//   ow_expired     : one-cycle pulse when the hold limit forced re-arbitration
interface prefix_rr_arbiter_if #(
    parameter int p_REQUESTERS = 8
);
    localparam int IW = $clog2(p_REQUESTERS);

    logic [p_REQUESTERS-1:0] iwv_req;
    logic [p_REQUESTERS-1:0] owv_grant;
    logic                    ow_grant_valid;
    logic [IW-1:0]           owv_grant_idx;
    logic                    ow_expired;

    modport master (
        output iwv_req,
        input  owv_grant, ow_grant_valid, owv_grant_idx, ow_expired
    );

    modport slave (
        input  iwv_req,
        output owv_grant, ow_grant_valid, owv_grant_idx, ow_expired
    );
endinterface

// File: rtl/prefix_rr_arbiter_prefix_or.sv
// rtl/prefix_rr_arbiter_prefix_or.sv - log-depth inclusive prefix-OR generator
//   p_WIDTH    : vector width (>= 2)
//   iwv_data   : input vector
//   owv_prefix : bit i is the OR of iwv_data[i:0]
module GenericPrefixOr #(
    parameter int p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] iwv_data,
    output logic [p_WIDTH-1:0] owv_prefix
);
    localparam int LV = $clog2(p_WIDTH);

    // Kogge-Stone style: stage k folds in the bit 2**k positions below.
    logic [LV:0][p_WIDTH-1:0] stage;

    assign stage[0] = iwv_data;

    for (genvar k = 0; k < LV; k++) begin : g_lvl
        for (genvar i = 0; i < p_WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_or
                assign stage[k+1][i] = stage[k][i] | stage[k][i-(1<<k)];
            end else begin : g_pass
                assign stage[k+1][i] = stage[k][i];
            end
        end
    end

    assign owv_prefix = stage[LV];
endmodule

// File: rtl/prefix_rr_arbiter.sv
// rtl/prefix_rr_arbiter.sv - round-robin arbiter with multi-cycle ownership and bounded hold
//   p_REQUESTERS : number of requesters (2..64)
//   p_MAX_HOLD   : max consecutive ownership cycles, 0 = unlimited
//   iw_clk       : clock, rising edge
//   iw_rst_n     : synchronous active-low reset
//   arb          : request/grant bundle (slave side)
module prefix_rr_arbiter
    import arb_pkg::*;
#(
    parameter int p_REQUESTERS = 8,
    parameter int p_MAX_HOLD   = 16
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    prefix_rr_arbiter_if.slave   arb
);
    localparam int N  = p_REQUESTERS;
    localparam int IW = $clog2(N);
    localparam int CW = (p_MAX_HOLD > 0) ? $clog2(p_MAX_HOLD + 1) : 1;

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    logic [N-1:0]  req;
    logic [N-1:0]  hi_mask;
    logic [N-1:0]  hi;
    logic [N-1:0]  p_hi, p_req, p_sel;
    logic [N-1:0]  win;
    logic [IW-1:0] win_idx;
    logic          hold_ok;

    assign req = arb.iwv_req;

    // Requesters strictly above the last owner get first pick.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i > int'(ptr_q));
        end
    end

    assign hi = req & hi_mask;

    GenericPrefixOr #(.p_WIDTH(N)) u_pfx_hi (
        .iwv_data   (hi),
        .owv_prefix (p_hi)
    );

    GenericPrefixOr #(.p_WIDTH(N)) u_pfx_req (
        .iwv_data   (req),
        .owv_prefix (p_req)
    );

    // Falling back to the full request vector is the wrap-around; the current
    // owner is only reachable this way, so it re-wins only when alone.
    assign p_sel   = (|hi) ? p_hi : p_req;
    assign win     = p_sel & ~(p_sel << 1);
    assign win_idx = IW'(f_onehot_to_idx(64'(win)));

    assign hold_ok = (p_MAX_HOLD == 0) || (cnt_q < CW'(p_MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d = ARB_OWN;
                    grant_d = win;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = CW'(1);
                end
            end
            ARB_OWN: begin
                if (req[ptr_q] && hold_ok) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (|req) begin
                    grant_d   = win;
                    idx_d     = win_idx;
                    ptr_d     = win_idx;
                    cnt_d     = CW'(1);
                    // Owner still requesting here means the hold limit ran out.
                    expired_d = req[ptr_q];
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= IW'(N - 1);
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign arb.owv_grant      = grant_q;
    assign arb.ow_grant_valid = |grant_q;
    assign arb.owv_grant_idx  = idx_q;
    assign arb.ow_expired     = expired_q;
endmodule
